// File: rtl/ci_initiator_if.sv
// Custom-instruction initiator bundle: pipeline request/response handshakes plus the shared CI bus.
interface ci_initiator_if #(
    parameter int unsigned LAT_WIDTH = 16
);
    logic                 reqValid;
    logic                 reqReady;
    logic [7:0]           reqCiN;
    logic [31:0]          reqValueA;
    logic [31:0]          reqValueB;
    logic                 ciStart;
    logic [7:0]           ciN;
    logic [31:0]          ciValueA;
    logic [31:0]          ciValueB;
    logic                 ciDone;
    logic [31:0]          ciResult;
    logic                 rspValid;
    logic                 rspReady;
    logic [31:0]          rspResult;
    logic [LAT_WIDTH-1:0] rspLatency;
    logic                 rspError;
    logic                 stall;

    modport master (
        input  reqValid, reqCiN, reqValueA, reqValueB, ciDone, ciResult, rspReady,
        output reqReady, ciStart, ciN, ciValueA, ciValueB,
        output rspValid, rspResult, rspLatency, rspError, stall
    );

    modport slave (
        output reqValid, reqCiN, reqValueA, reqValueB, ciDone, ciResult, rspReady,
        input  reqReady, ciStart, ciN, ciValueA, ciValueB,
        input  rspValid, rspResult, rspLatency, rspError, stall
    );
endinterface

// File: rtl/ci_initiator.sv
// CI initiator: issues one custom instruction at a time, waits for done, returns result and latency.
// Optional CI_TIMEOUT_EN aborts an instruction after TIMEOUT_CYCLES with rspError=1.
module ci_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LAT_WIDTH      = 16
) (
    input logic            clock,
    input logic            reset,
    ci_initiator_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;

    state_t               state_q, state_d;
    logic [LAT_WIDTH-1:0] lat_q, lat_d;
    logic [7:0]           n_d;
    logic [31:0]          a_d, b_d, res_d;
    logic [LAT_WIDTH-1:0] rlat_d;
    logic                 err_d;
    logic                 timeout_c;

`ifdef CI_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    // Counts cycles since ciStart independently of the (possibly narrower) latency counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if (state_q == S_IDLE) begin
            tmo_q <= TMO_W'(1);
        end else if (state_d == S_WAIT) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign timeout_c = ((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                       (tmo_q == TMO_W'(TIMEOUT_CYCLES));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and next register values; bus registers double as the operand latch.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        n_d     = bus.ciN;
        a_d     = bus.ciValueA;
        b_d     = bus.ciValueB;
        res_d   = bus.rspResult;
        rlat_d  = bus.rspLatency;
        err_d   = bus.rspError;
        case (state_q)
            S_IDLE: begin
                if (bus.reqValid) begin
                    state_d = S_ISSUE;
                    n_d     = bus.reqCiN;
                    a_d     = bus.reqValueA;
                    b_d     = bus.reqValueB;
                    lat_d   = LAT_WIDTH'(1);
                end
            end
            S_ISSUE, S_WAIT: begin
                if (bus.ciDone || timeout_c) begin
                    state_d = S_RESP;
                    n_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                    rlat_d  = lat_q;
                    err_d   = !bus.ciDone;
                    res_d   = bus.ciDone ? bus.ciResult : 32'h0;
                end else begin
                    state_d = S_WAIT;
                    if (lat_q != LAT_MAX) begin
                        lat_d = lat_q + LAT_WIDTH'(1);
                    end
                end
            end
            S_RESP: begin
                if (bus.rspReady) begin
                    state_d = S_IDLE;
                    res_d   = '0;
                    rlat_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset clears the bus immediately and discards any in-flight op.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lat_q          <= '0;
            bus.reqReady   <= 1'b1;
            bus.ciStart    <= 1'b0;
            bus.ciN        <= '0;
            bus.ciValueA   <= '0;
            bus.ciValueB   <= '0;
            bus.rspValid   <= 1'b0;
            bus.rspResult  <= '0;
            bus.rspLatency <= '0;
            bus.rspError   <= 1'b0;
            bus.stall      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lat_q          <= lat_d;
            bus.reqReady   <= (state_d == S_IDLE);
            bus.ciStart    <= (state_d == S_ISSUE);
            bus.ciN        <= n_d;
            bus.ciValueA   <= a_d;
            bus.ciValueB   <= b_d;
            bus.rspValid   <= (state_d == S_RESP);
            bus.rspResult  <= res_d;
            bus.rspLatency <= rlat_d;
            bus.rspError   <= err_d;
            bus.stall      <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_ci_initiator.sv
// Directed plus randomized bench for ci_initiator with a responder and a spec-level result model.
module tb_ci_initiator;
    localparam int unsigned LAT_W = 4;
    localparam int unsigned TMO   = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    ci_initiator_if #(.LAT_WIDTH(LAT_W)) bus ();

    ci_initiator #(.TIMEOUT_CYCLES(TMO), .LAT_WIDTH(LAT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Spec-level outcome: done 'd' cycles after start means d+1 cycles counted from ciStart.
    task automatic model(input int unsigned d, input logic [31:0] r,
                         output logic [31:0] er, output logic [LAT_W-1:0] el,
                         output logic ee, output int unsigned cyc);
        int unsigned cnt;
        cnt = d + 1;
        er  = r;
        ee  = 1'b0;
        cyc = cnt;
`ifdef CI_TIMEOUT_EN
        if (cnt > TMO) begin
            er  = 32'h0;
            ee  = 1'b1;
            cyc = TMO;
        end
`endif
        el = (cyc > ((1 << LAT_W) - 1)) ? LAT_W'((1 << LAT_W) - 1) : LAT_W'(cyc);
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_reqReady"}, 64'(bus.reqReady), 64'd1);
        chk({tag, "_ciStart"}, 64'(bus.ciStart), 64'd0);
        chk({tag, "_rspValid"}, 64'(bus.rspValid), 64'd0);
        chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
    endtask

    // One full instruction: request, responder done after 'd' cycles, response held 'hold' cycles.
    task automatic run_txn(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned d, input logic [31:0] r, input int unsigned hold);
        logic [31:0]      er;
        logic [LAT_W-1:0] el;
        logic             ee;
        int unsigned      cyc;
        int unsigned      k;
        model(d, r, er, el, ee, cyc);
        @(negedge clock);
        chk("accept_reqReady", 64'(bus.reqReady), 64'd1);
        bus.reqValid  = 1'b1;
        bus.reqCiN    = n;
        bus.reqValueA = a;
        bus.reqValueB = b;
        @(negedge clock);
        bus.reqValid  = 1'b0;
        bus.reqCiN    = 8'($urandom);
        bus.reqValueA = $urandom;
        chk("issue_ciStart", 64'(bus.ciStart), 64'd1);
        chk("issue_stall", 64'(bus.stall), 64'd1);
        chk("issue_reqReady", 64'(bus.reqReady), 64'd0);
        k = 0;
        while (!bus.rspValid && k < 200) begin
            chk("bus_ciN", 64'(bus.ciN), 64'(n));
            chk("bus_ciValueA", 64'(bus.ciValueA), 64'(a));
            chk("bus_ciValueB", 64'(bus.ciValueB), 64'(b));
            if (k > 0) chk("wait_ciStart", 64'(bus.ciStart), 64'd0);
            bus.ciDone   = (k == d);
            bus.ciResult = (k == d) ? r : $urandom;
            @(negedge clock);
            k = k + 1;
        end
        bus.ciDone = 1'b0;
        chk("rsp_cycles", 64'(k), 64'(cyc));
        chk("rsp_valid", 64'(bus.rspValid), 64'd1);
        chk("rsp_result", 64'(bus.rspResult), 64'(er));
        chk("rsp_latency", 64'(bus.rspLatency), 64'(el));
        chk("rsp_error", 64'(bus.rspError), 64'(ee));
        chk("rsp_ciN_zero", 64'(bus.ciN), 64'd0);
        chk("rsp_ciValueA_zero", 64'(bus.ciValueA), 64'd0);
        for (int h = 0; h < int'(hold); h++) begin
            bus.ciDone   = $urandom_range(0, 1) == 1;
            bus.ciResult = $urandom;
            @(negedge clock);
            chk("hold_valid", 64'(bus.rspValid), 64'd1);
            chk("hold_result", 64'(bus.rspResult), 64'(er));
            chk("hold_latency", 64'(bus.rspLatency), 64'(el));
            chk("hold_reqReady", 64'(bus.reqReady), 64'd0);
            chk("hold_stall", 64'(bus.stall), 64'd1);
            chk("hold_ciStart", 64'(bus.ciStart), 64'd0);
        end
        bus.ciDone   = 1'b0;
        bus.rspReady = 1'b1;
        @(negedge clock);
        bus.rspReady = 1'b0;
        idle_checks("release");
    endtask

    initial begin
        bus.reqValid  = 1'b0;
        bus.reqCiN    = '0;
        bus.reqValueA = '0;
        bus.reqValueB = '0;
        bus.ciDone    = 1'b0;
        bus.ciResult  = '0;
        bus.rspReady  = 1'b0;
        #12;
        idle_checks("reset");
        chk("reset_ciN", 64'(bus.ciN), 64'd0);
        chk("reset_rspLatency", 64'(bus.rspLatency), 64'd0);
        reset = 1'b1;

        run_txn(8'h05, 32'd2, 32'd0, 0, 32'h1234, 0);
        run_txn(8'h3C, 32'h1111_2222, 32'h3333_4444, 4, 32'hCAFE_F00D, 0);
        run_txn(8'h77, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2, 32'hDEAD_BEEF, 10);
        run_txn(8'h11, 32'h1, 32'h2, 19, 32'h0BAD_CAFE, 1);
        run_txn(8'h22, 32'h3, 32'h4, 7, 32'h600D_D00D, 0);
        run_txn(8'h33, 32'h5, 32'h6, 100, 32'h1357_9BDF, 0);

        // Reset between clock edges while the instruction is waiting for done.
        @(negedge clock);
        bus.reqValid  = 1'b1;
        bus.reqCiN    = 8'h99;
        bus.reqValueA = 32'hFFFF_0000;
        bus.reqValueB = 32'h0000_FFFF;
        @(negedge clock);
        bus.reqValid = 1'b0;
        repeat (3) @(negedge clock);
        chk("prereset_stall", 64'(bus.stall), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("areset_ciStart", 64'(bus.ciStart), 64'd0);
        chk("areset_ciN", 64'(bus.ciN), 64'd0);
        chk("areset_ciValueA", 64'(bus.ciValueA), 64'd0);
        chk("areset_ciValueB", 64'(bus.ciValueB), 64'd0);
        chk("areset_rspValid", 64'(bus.rspValid), 64'd0);
        chk("areset_stall", 64'(bus.stall), 64'd0);
        chk("areset_reqReady", 64'(bus.reqReady), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            bus.ciDone = 1'b1;
            @(negedge clock);
            idle_checks("post_reset");
        end
        bus.ciDone = 1'b0;
        run_txn(8'h42, 32'h0000_0042, 32'h4200_0000, 3, 32'h4242_4242, 0);

        for (int i = 0; i < 20; i++) begin
            run_txn(8'($urandom), $urandom, $urandom, $urandom_range(0, 12), $urandom,
                    $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
